// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target endpoint: fixed 7-bit address, ACKs every byte, transmits caller bytes on reads
`timescale 1ns/1ps
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       scl,
  inout  wire        sda,
  input  logic       msb_lsb,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_req,
  output logic       addressed,
  output logic       rw,
  output logic       nack_seen,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE
  } state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       sda_low;
  logic       ack_drv;

  assign sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  logic       scl_h, sda_h, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] addr_next, rx_next, tx_next;
  logic       tx_first, tx_next_bit;

  assign scl_h     = scl_sync[1];
  assign sda_h     = sda_sync[1];
  assign scl_rise  = scl_h & ~scl_prev;
  assign scl_fall  = ~scl_h & scl_prev;
  // SCL must be high on both samples so an SDA move next to an SCL edge is not a bus event
  assign start_det = scl_h & scl_prev & sda_prev & ~sda_h;
  assign stop_det  = scl_h & scl_prev & ~sda_prev & sda_h;

  assign addr_next   = {shreg[6:0], sda_h};
  assign rx_next     = msb_lsb ? {shreg[6:0], sda_h} : {sda_h, shreg[7:1]};
  assign tx_next     = msb_lsb ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
  assign tx_first    = msb_lsb ? tx_byte[7] : tx_byte[0];
  assign tx_next_bit = msb_lsb ? shreg[6] : shreg[1];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      sda_low   <= 1'b0;
      ack_drv   <= 1'b0;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      addressed <= 1'b0;
      rw        <= 1'b0;
      nack_seen <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      nack_seen <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        sda_low   <= 1'b0;
        ack_drv   <= 1'b0;
        addressed <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_det) begin
        state     <= IDLE;
        sda_low   <= 1'b0;
        ack_drv   <= 1'b0;
        addressed <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= addr_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_next[7:1] == SLAVE_ADDR) begin
                rw        <= addr_next[0];
                addressed <= 1'b1;
                tx_req    <= addr_next[0];
                state     <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          // first fall starts the ACK drive, the 9th fall ends it
          ADDR_ACK, RX_ACK: if (scl_fall) begin
            if (!ack_drv) begin
              sda_low <= 1'b1;
              ack_drv <= 1'b1;
            end else begin
              ack_drv <= 1'b0;
              bit_cnt <= 3'd0;
              if (state == ADDR_ACK && rw) begin
                shreg   <= tx_byte;
                sda_low <= ~tx_first;
                state   <= TX_DATA;
              end else begin
                sda_low <= 1'b0;
                state   <= RX_DATA;
              end
            end
          end
          RX_DATA: if (scl_rise) begin
            shreg   <= rx_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_byte  <= rx_next;
              rx_valid <= 1'b1;
              state    <= RX_ACK;
            end
          end
          TX_DATA: if (scl_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_low <= 1'b0;
              state   <= TX_ACK;
            end else begin
              shreg   <= tx_next;
              sda_low <= ~tx_next_bit;
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_h) begin
                tx_req <= 1'b1;
              end else begin
                nack_seen <= 1'b1;
                state     <= IGNORE;
              end
            end else if (scl_fall) begin
              shreg   <= tx_byte;
              sda_low <= ~tx_first;
              bit_cnt <= 3'd0;
              state   <= TX_DATA;
            end
          end
          default: sda_low <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed and randomized bus-level bench for i2c_slave
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 60;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       msb_lsb = 1'b1;
  logic [7:0] tx_byte = 8'hFF;
  logic [7:0] rx_byte;
  logic       rx_valid, tx_req, addressed, rw, nack_seen, busy;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .arstn(arstn), .scl(scl), .sda(sda), .msb_lsb(msb_lsb),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_byte(tx_byte), .tx_req(tx_req),
    .addressed(addressed), .rw(rw), .nack_seen(nack_seen), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0, txr_cnt = 0, nack_cnt = 0, pulse_err = 0, drove = 0;
  logic rx_p = 0, txr_p = 0, nk_p = 0;
  logic [7:0] rx_log[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] d, got;
  bit         a;
  int         n;

  // pulse monitor and tx_byte supplier, away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin rx_cnt++; rx_log.push_back(rx_byte); end
    if (tx_req) begin
      txr_cnt++;
      tx_byte = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
    end
    if (nack_seen) nack_cnt++;
    if ((rx_valid && rx_p) || (tx_req && txr_p) || (nack_seen && nk_p)) pulse_err++;
    if (!m_low && sda === 1'b0) drove++;
    rx_p = rx_valid; txr_p = tx_req; nk_p = nack_seen;
  end

  function automatic logic bus();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  // data byte as it should appear to the slave given the wire order MSB-first
  function automatic logic [7:0] order(input logic [7:0] v, input logic msb);
    return msb ? v : rev8(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cond();
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    m_low = 1'b1; #Q;
    scl = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] v, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~v[i]; #Q;
      scl = 1'b1; #(2*Q);
      scl = 1'b0; #Q;
    end
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    ack = (sda === 1'b0);
    #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input bit nack, output logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; #Q;
      scl = 1'b1; #Q;
      v[i] = bus();
      #Q;
      scl = 1'b0; #Q;
    end
    m_low = ~nack; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
    m_low = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #23;
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_addressed", addressed, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_nack", nack_seen, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", bus(), 1'b1);
    arstn = 1'b1; #100;

    // write 0x3C, 0xC3 MSB first
    rx_log.delete(); rx_cnt = 0;
    start_cond();
    check("wr_busy", busy, 1'b1);
    write_byte(8'hA0, a); check("wr_addr_ack", a, 1'b1);
    check("wr_addressed", addressed, 1'b1);
    check("wr_rw", rw, 1'b0);
    write_byte(8'h3C, a); check("wr_d0_ack", a, 1'b1);
    write_byte(8'hC3, a); check("wr_d1_ack", a, 1'b1);
    check("wr_addressed_pre_stop", addressed, 1'b1);
    stop_cond();
    check("wr_rx_cnt", rx_cnt, 2);
    check("wr_rx0", rx_log[0], 8'h3C);
    check("wr_rx1", rx_log[1], 8'hC3);
    check("wr_busy_after", busy, 1'b0);
    check("wr_addressed_after", addressed, 1'b0);

    // address mismatch
    rx_cnt = 0; drove = 0;
    start_cond();
    write_byte(8'hA2, a); check("mm_addr_nack", a, 1'b0);
    check("mm_busy", busy, 1'b1);
    check("mm_addressed", addressed, 1'b0);
    write_byte(8'h55, a); check("mm_data_nack", a, 1'b0);
    stop_cond();
    check("mm_rx_cnt", rx_cnt, 0);
    check("mm_never_driven", drove, 0);
    check("mm_busy_after", busy, 1'b0);

    // read 0x96 (ACK), 0x5A (NACK)
    tx_q.delete(); tx_q.push_back(8'h96); tx_q.push_back(8'h5A);
    txr_cnt = 0; nack_cnt = 0;
    start_cond();
    write_byte(8'hA1, a); check("rd_addr_ack", a, 1'b1);
    check("rd_rw", rw, 1'b1);
    read_byte(1'b0, got); check("rd_b0", got, 8'h96);
    read_byte(1'b1, got); check("rd_b1", got, 8'h5A);
    check("rd_released", bus(), 1'b1);
    check("rd_tx_req_cnt", txr_cnt, 2);
    check("rd_nack_cnt", nack_cnt, 1);
    stop_cond();

    // repeated START
    rx_log.delete(); rx_cnt = 0; nack_cnt = 0;
    start_cond();
    write_byte(8'hA0, a); check("rs_addr_ack", a, 1'b1);
    write_byte(8'h11, a);
    check("rs_addressed_before", addressed, 1'b1);
    start_cond();
    check("rs_addressed_dropped", addressed, 1'b0);
    check("rs_busy", busy, 1'b1);
    d = 8'($urandom); tx_q.delete(); tx_q.push_back(d);
    write_byte(8'hA1, a); check("rs_addr2_ack", a, 1'b1);
    check("rs_addressed_again", addressed, 1'b1);
    check("rs_rw", rw, 1'b1);
    read_byte(1'b1, got); check("rs_read", got, d);
    stop_cond();
    check("rs_rx_byte", rx_byte, 8'h11);
    check("rs_nack_cnt", nack_cnt, 1);

    // LSB-first receive: wire bits 1,0,0,0,0,0,0,0
    msb_lsb = 1'b0;
    start_cond();
    write_byte(8'hA0, a); check("lsb_addr_ack", a, 1'b1);
    write_byte(8'h80, a);
    stop_cond();
    check("lsb_rx_byte", rx_byte, 8'h01);
    msb_lsb = 1'b1;

    // reset while the block drives a 0 data bit
    tx_q.delete(); tx_q.push_back(8'h00);
    start_cond();
    write_byte(8'hA1, a);
    m_low = 1'b0; #Q;
    scl = 1'b1; #Q;
    check("mr_driving_zero", bus(), 1'b0);
    arstn = 1'b0; #1;
    check("mr_sda_released", bus(), 1'b1);
    check("mr_addressed", addressed, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_rw", rw, 1'b0);
    check("mr_rx_byte", rx_byte, 8'h00);
    #Q; scl = 1'b0; #Q;
    arstn = 1'b1; #Q;
    scl = 1'b1; #(2*Q);
    rx_log.delete(); rx_cnt = 0;
    start_cond();
    write_byte(8'hA0, a); check("mr_post_addr_ack", a, 1'b1);
    d = 8'($urandom);
    write_byte(d, a); check("mr_post_data_ack", a, 1'b1);
    stop_cond();
    check("mr_post_rx", rx_log[0], d);

    // randomized transfers against the reference model
    for (int it = 0; it < 8; it++) begin
      msb_lsb = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      rx_log.delete(); exp_q.delete(); tx_q.delete();
      rx_cnt = 0; txr_cnt = 0; nack_cnt = 0;
      if ($urandom_range(0, 1) == 1) begin
        start_cond();
        write_byte(8'hA0, a); check("rnd_wr_addr_ack", a, 1'b1);
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          write_byte(d, a); check("rnd_wr_ack", a, 1'b1);
          exp_q.push_back(order(d, msb_lsb));
        end
        stop_cond();
        check("rnd_wr_cnt", rx_cnt, n);
        for (int k = 0; k < n; k++) check("rnd_wr_data", rx_log[k], exp_q[k]);
      end else begin
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          tx_q.push_back(d);
          exp_q.push_back(order(d, msb_lsb));
        end
        start_cond();
        write_byte(8'hA1, a); check("rnd_rd_addr_ack", a, 1'b1);
        for (int k = 0; k < n; k++) begin
          read_byte(k == n - 1, got);
          check("rnd_rd_data", got, exp_q[k]);
        end
        stop_cond();
        check("rnd_rd_req_cnt", txr_cnt, n);
        check("rnd_rd_nack_cnt", nack_cnt, 1);
      end
      check("rnd_busy_after", busy, 1'b0);
    end

    check("pulse_width", pulse_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) endpoint for the I2C master used behind the APB bridge. It listens on an externally driven SCL/SDA pair and detects START and STOP conditions. It matches a fixed 7-bit address, ACKs its address and every received byte, and transmits caller-supplied bytes on read transfers. It is used as an on-chip peripheral model and as the loop-back partner for the master in system tests.

## Interface

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.

Ports:
- clk  input  1  system clock; must be at least 20× the SCL frequency.
- arstn  input  1  reset, asynchronous, active-low.
- scl  input  1  bus clock from the master. No clock stretching.
- sda  inout  1  open-drain data. The block drives 1'b0 or 1'bz only.
- msb_lsb  input  1  data byte bit order. 1 = MSB first, 0 = LSB first. Does not affect the address byte, which is always MSB first.
- rx_byte  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-clk pulse when rx_byte updates.
- tx_byte  input  8  next byte to transmit in a read transfer.
- tx_req  output  1  one-clk pulse requesting the next tx_byte.
- addressed  output  1  high from address match until STOP or START.
- rw  output  1  R/W bit of the matched address byte. 1 = read.
- nack_seen  output  1  one-clk pulse when the master NACKs a transmitted byte.
- busy  output  1  high between a START and a STOP.

## Operation

Input conditioning:
- scl and sda each pass through a 2-FF synchronizer (reset value 1), followed by a previous-value register.
- Rise and fall events are detected on the synchronized values.

Bus events:
- START: sda falls while scl is high. STOP: sda rises while scl is high.
- START and STOP take priority over every state.
  - START from any state: go to ADDR, clear bit_cnt, release sda, deassert addressed, set busy.
  - STOP from any state: go to IDLE, release sda, clear addressed and busy.

Bit timing:
- Bits are sampled on scl rise.
- sda drive changes are applied only on scl fall.

States:
- IDLE: sda released; waits for START.
- ADDR: shifts in 8 bits. On the 8th scl rise, compare bits [7:1] to SLAVE_ADDR.
  - Match: latch rw, set addressed, go to ADDR_ACK.
  - Mismatch: go to IGNORE.
- ADDR_ACK: drive sda low on the next scl fall and hold it low through the 9th clock. On the 9th scl fall:
  - rw=0: release sda, go to RX_DATA.
  - rw=1: go to TX_DATA.
- RX_DATA: shifts in 8 bits in the order set by msb_lsb.
  - On the 8th scl rise: update rx_byte, pulse rx_valid, go to RX_ACK.
- RX_ACK: the byte is always ACKed. Drive sda low on the next scl fall; release on the 9th scl fall; return to RX_DATA.
- TX_DATA:
  - Entry on the 9th scl fall: latch tx_byte into the shift register and drive its first bit.
  - Drive the next bit on each following scl fall. A 1 bit means sda released, a 0 bit means sda driven low.
  - After the 8th bit's scl fall, release sda and go to TX_ACK.
- TX_ACK: sample sda on the 9th scl rise.
  - sda=0 (ACK): pulse tx_req, return to TX_DATA at the 9th scl fall.
  - sda=1 (NACK): pulse nack_seen, go to IGNORE.
- tx_req also pulses on entry to ADDR_ACK when rw=1.
- IGNORE: sda released; waits for START or STOP.

Counters:
- bit_cnt is 3 bits and wraps 7→0 at each byte boundary.
- Shift registers are 8 bits.

## Timing

- Event latency: 3 clk from a pin edge to the resulting register update (2 synchronizer stages plus 1 detect stage).
- rx_valid, tx_req and nack_seen are each high for exactly 1 clk.
- tx_byte must be stable from the tx_req pulse until the next scl fall. This leaves at least half an SCL period minus 3 clk.
- Reset values: rx_byte=0, rx_valid=0, tx_req=0, addressed=0, rw=0, nack_seen=0, busy=0, sda=z, state=IDLE.
- Reset asserted mid-transfer releases sda asynchronously, including while ACK or a 0 data bit is being driven.
- An SCL glitch shorter than 1 clk may be missed. No filtering beyond the synchronizer.

## Test plan

- Write transfer, SLAVE_ADDR=0x50, msb_lsb=1: master sends START, 0xA0, 0x3C, 0xC3, STOP.
  - sda is low on all three 9th clocks.
  - rx_valid pulses twice, with rx_byte 0x3C then 0xC3.
  - addressed=1 and rw=0 until STOP, then busy=0.
- Address mismatch: master sends START, 0xA2, 0x55, STOP.
  - sda is never driven; the master sees NACK.
  - rx_valid and addressed stay 0; busy goes 1 then 0.
- Read transfer: START, 0xA1, then tx_byte 0x96 followed by 0x5A; master ACKs the first byte and NACKs the second, then STOP.
  - Bus carries 1001_0110 then 0101_1010.
  - tx_req pulses twice; nack_seen pulses once.
  - sda is released after the second byte.
- Repeated START: START, 0xA0, 0x11, then START, 0xA1, read one byte with NACK.
  - rx_byte=0x11.
  - addressed drops at the repeated START and rises again with rw=1.
- LSB-first receive: msb_lsb=0, write; master clocks data bits 1,0,0,0,0,0,0,0 → rx_byte=0x01.
- Reset mid-read while the block is driving a 0 bit: arstn low → sda=z immediately and all outputs at their reset values. After release, a following write to 0xA0 is ACKed normally.
